trace_buffer_arbiter: RTL and testbench
=======================================

# trace_buffer_arbiter

Shared trace-buffer controller between the per-stage trace trackers and the trace readout path. It arbitrates round-robin between the IF-stage and data-memory-stage trackers, tags each accepted record with a monotonic sequence number and stores it in an internal circular buffer. A valid/ready drain port hands records to the downstream consumer. Halt and flush controls let the debug host freeze or empty the buffer without a global reset.

## Interface
- ENTRY_WIDTH, 128, width of one opaque trace record (addr, instruction, start/end times)
- TRACE_BUFFER_SIZE, 128, number of entries; power of two, ≥2
- TAG_WIDTH, 32, width of the sequence tag
- IDX_W, $clog2(TRACE_BUFFER_SIZE), derived pointer width (localparam)
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- halt  in  1  stop accepting records; drain continues
- flush  in  1  single-cycle pulse: discard all stored records
- if_valid  in  1  IF tracker has a record
- if_entry  in  ENTRY_WIDTH  IF record
- if_ready  out  1  IF record accepted this cycle when if_valid & if_ready
- mem_valid  in  1  data-memory tracker has a record
- mem_entry  in  ENTRY_WIDTH  data-memory record
- mem_ready  out  1  data-memory record accepted when mem_valid & mem_ready
- out_valid  out  1  oldest record available
- out_entry  out  ENTRY_WIDTH  oldest record
- out_src  out  1  source of oldest record (0 = IF, 1 = MEM)
- out_tag  out  TAG_WIDTH  sequence tag of oldest record
- out_ready  in  1  consumer pops when out_valid & out_ready
- occupancy  out  IDX_W+1  stored record count, 0..TRACE_BUFFER_SIZE
- overflow_count  out  16  records overwritten (see Configuration)

## Operation
- States: RUN, HALT, FLUSH. Reset → RUN.
- RUN: flush → FLUSH; else halt → HALT.
- HALT: flush → FLUSH; else !halt → RUN. Both readies held 0; drain unaffected.
- FLUSH: lasts exactly one cycle. Read/write pointers and occupancy cleared; tag counter and overflow_count kept. Readies 0, out_valid 0. Exits to HALT if halt, else RUN.
- Arbitration in RUN, combinational from valids, last_grant register and full:
  - If exactly one valid: that source is granted.
  - If both valid: the source not granted last time is granted. last_grant resets to MEM, so IF wins the first contest.
  - Only the granted source's ready is 1; at most one write per cycle.
- last_grant updates only on an accepted write.
- Accepted write stores {src, tag_counter, entry} at wr_ptr. Then wr_ptr+1 mod SIZE and tag_counter+1 (wraps at 2^TAG_WIDTH).
- Drain:
  - out_valid = (occupancy != 0) and state != FLUSH.
  - out_* are driven from the entry at rd_ptr.
  - A pop advances rd_ptr mod SIZE.
- Occupancy: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full (occupancy == SIZE), macro absent: both readies 0, even if a pop occurs in the same cycle.
- Empty: a pop cannot occur; push when empty gives out_valid=1 the next cycle.

## Timing
- Reset values, applied the cycle after rst is sampled high:
  - state RUN
  - pointers, occupancy, tag_counter, overflow_count 0
  - out_valid 0, out_entry/out_src/out_tag 0
  - if_ready/mem_ready 0 while rst high
  - Buffer contents need not be cleared.
- Priority: rst > flush > halt > normal operation.
- Readies are combinational from valids and registered state, with no combinational path from out_ready.
- Latency from accepted write to out_valid is 1 cycle, when the buffer was empty.
- Pop-to-next-entry latency is 1 cycle; sustained throughput is one push and one pop per cycle.
- A flush or rst in the same cycle as a valid handshake discards that record; no tag is consumed.

## Configuration
- TRACE_ARB_OVERWRITE_EN defined:
  - When full, arbitration proceeds normally and the granted ready stays 1.
  - The accepted write overwrites the oldest entry; rd_ptr advances and occupancy stays SIZE.
  - overflow_count increments, saturating at 16'hFFFF.
  - Push+pop when full behaves as an ordinary push+pop, with no overflow.
- Not defined: backpressure when full as above; overflow_count is constant 0.

## Test plan
- Reset, then IF pushes entry 0xA5 → out_valid=1 one cycle later, out_tag=0, out_src=0, occupancy=1.
- Both valid for 4 cycles, out_ready=1 → grants IF, MEM, IF, MEM; tags 0,1,2,3 drain in that order.
- SIZE=4, macro off, 5 IF pushes with out_ready=0 → if_ready=0 on 5th; occupancy=4; pop one → if_ready=1 same cycle next arbitration, 5th accepted with tag 4.
- SIZE=4, macro on, 6 pushes with no pops → occupancy=4, overflow_count=2, out_tag=2 at head.
- 3 records stored, flush pulse → next cycle occupancy=0, out_valid=0; following push gets tag 3.
- halt high with mem_valid=1 → mem_ready=0 throughout; stored records still drain; deassert halt → accepted next cycle.

Source files
------------

// File: rtl/trace_buffer_arbiter.sv
// Round-robin arbiter between IF and MEM trace trackers feeding a tagged circular trace buffer.
// Optional overwrite-when-full mode is enabled by defining TRACE_ARB_OVERWRITE_EN.
module trace_buffer_arbiter #(
  parameter int ENTRY_WIDTH       = 128,
  parameter int TRACE_BUFFER_SIZE = 128,
  parameter int TAG_WIDTH         = 32,
  localparam int IDX_W            = $clog2(TRACE_BUFFER_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [ENTRY_WIDTH-1:0] if_entry,
  output logic                   if_ready,
  input  logic                   mem_valid,
  input  logic [ENTRY_WIDTH-1:0] mem_entry,
  output logic                   mem_ready,
  output logic                   out_valid,
  output logic [ENTRY_WIDTH-1:0] out_entry,
  output logic                   out_src,
  output logic [TAG_WIDTH-1:0]   out_tag,
  input  logic                   out_ready,
  output logic [IDX_W:0]         occupancy,
  output logic [15:0]            overflow_count
);

  localparam int REC_W = 1 + TAG_WIDTH + ENTRY_WIDTH;
  localparam logic [IDX_W:0] OCC_FULL = (IDX_W+1)'(TRACE_BUFFER_SIZE);
  localparam logic SRC_IF  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

`ifdef TRACE_ARB_OVERWRITE_EN
  localparam logic OVERWRITE = 1'b1;
`else
  localparam logic OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [IDX_W:0]       occ_q, occ_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 last_grant_q, last_grant_d;

  logic [REC_W-1:0]     mem_q [TRACE_BUFFER_SIZE];
  logic [REC_W-1:0]     rd_data_q;
  logic                 byp_q, byp_d;
  logic [REC_W-1:0]     byp_data_q, byp_data_d;
  logic                 zero_q, zero_d;

  logic                 full;
  logic                 accept_ok;
  logic                 grant_mem;
  logic                 wr_en;
  logic                 pop;
  logic                 overwrite_evt;
  logic [REC_W-1:0]     wr_rec;
  logic [REC_W-1:0]     out_rec;

  // Arbitration and handshakes; readies never depend on out_ready or flush.
  always_comb begin
    full      = (occ_q == OCC_FULL);
    accept_ok = !rst && (state_q == ST_RUN) && (!full || OVERWRITE);
    grant_mem = mem_valid && (!if_valid || (last_grant_q == SRC_IF));
    if_ready  = accept_ok && if_valid && !grant_mem;
    mem_ready = accept_ok && grant_mem;
    // A handshake coinciding with flush is taken but discarded.
    wr_en     = ((if_valid && if_ready) || (mem_valid && mem_ready)) && !flush;
    wr_rec    = {grant_mem, tag_q, (grant_mem ? mem_entry : if_entry)};
    out_valid = (occ_q != '0) && (state_q != ST_FLUSH);
    pop       = out_valid && out_ready && !flush;
    overwrite_evt = wr_en && full && !pop;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush)     state_d = ST_FLUSH;
        else if (halt) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (flush)      state_d = ST_FLUSH;
        else if (!halt) state_d = ST_RUN;
      end
      ST_FLUSH: state_d = halt ? ST_HALT : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Pointer, occupancy, tag and round-robin bookkeeping.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    tag_d        = tag_q;
    last_grant_d = last_grant_q;

    if (wr_en) begin
      wr_ptr_d     = wr_ptr_q + IDX_W'(1);
      tag_d        = tag_q + TAG_WIDTH'(1);
      last_grant_d = grant_mem ? SRC_MEM : SRC_IF;
    end
    // An overwrite drops the oldest record, so the head moves with the write.
    if (pop || overwrite_evt) begin
      rd_ptr_d = rd_ptr_q + IDX_W'(1);
    end
    if (wr_en && !pop && !full) begin
      occ_d = occ_q + (IDX_W+1)'(1);
    end else if (pop && !wr_en) begin
      occ_d = occ_q - (IDX_W+1)'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  // Head prefetch: the RAM read port is addressed with the next read pointer;
  // a write landing on that same slot is forwarded instead.
  always_comb begin
    byp_d      = wr_en && (wr_ptr_q == rd_ptr_d);
    byp_data_d = wr_rec;
    zero_d     = (occ_d == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_rec;
    end
    rd_data_q <= mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      tag_q        <= '0;
      last_grant_q <= SRC_MEM;
      byp_q        <= 1'b0;
      byp_data_q   <= '0;
      zero_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
      byp_q        <= byp_d;
      byp_data_q   <= byp_data_d;
      zero_q       <= zero_d;
    end
  end

`ifdef TRACE_ARB_OVERWRITE_EN
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (overwrite_evt && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign overflow_count = ovf_q;
`else
  assign overflow_count = 16'd0;
`endif

  // Stale RAM contents are masked while the buffer is empty.
  assign out_rec   = zero_q ? '0 : (byp_q ? byp_data_q : rd_data_q);
  assign out_src   = out_rec[REC_W-1];
  assign out_tag   = out_rec[ENTRY_WIDTH +: TAG_WIDTH];
  assign out_entry = out_rec[ENTRY_WIDTH-1:0];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_trace_buffer_arbiter.sv
// Scoreboard bench for trace_buffer_arbiter: directed pushes queue expected records, a monitor checks drains.
module tb_trace_buffer_arbiter;

  localparam int EW = 128;
  localparam int SZ = 4;
  localparam int TW = 32;
  localparam int IW = $clog2(SZ);

  logic          clk = 1'b0;
  logic          rst, halt, flush;
  logic          if_valid, mem_valid, out_ready;
  logic [EW-1:0] if_entry, mem_entry;
  logic          if_ready, mem_ready, out_valid, out_src;
  logic [EW-1:0] out_entry;
  logic [TW-1:0] out_tag;
  logic [IW:0]   occupancy;
  logic [15:0]   overflow_count;

  typedef struct packed {
    logic          src;
    logic [TW-1:0] tag;
    logic [EW-1:0] entry;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  trace_buffer_arbiter #(.ENTRY_WIDTH(EW), .TRACE_BUFFER_SIZE(SZ), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .halt(halt), .flush(flush),
    .if_valid(if_valid), .if_entry(if_entry), .if_ready(if_ready),
    .mem_valid(mem_valid), .mem_entry(mem_entry), .mem_ready(mem_ready),
    .out_valid(out_valid), .out_entry(out_entry), .out_src(out_src), .out_tag(out_tag),
    .out_ready(out_ready), .occupancy(occupancy), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic src, input int tag, input logic [EW-1:0] e);
    rec_t r;
    r.src = src;
    r.tag = TW'(tag);
    r.entry = e;
    exp_q.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; flush = 1'b0;
    if_valid = 1'b0; mem_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) cyc();
    out_ready = 1'b0;
    neg();
    chk("drained_occ", 192'(occupancy), 192'(0));
    cyc();
  endtask

  // Drain monitor: every pop the DUT presents is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected: got tag %0d expected no record", out_tag);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("drain_rec", 192'({out_src, out_tag, out_entry}), 192'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g [4];
    g = '{1'b0, 1'b1, 1'b0, 1'b1};
    if_entry = '0; mem_entry = '0;

    // Reset state, readies held low while rst is high
    rst = 1'b1; halt = 1'b0; flush = 1'b0; out_ready = 1'b0;
    if_valid = 1'b1; mem_valid = 1'b0; if_entry = 128'h1;
    cyc(); cyc();
    neg();
    chk("rst_if_ready", 192'(if_ready), 192'(0));
    chk("rst_out_valid", 192'(out_valid), 192'(0));
    chk("rst_occ", 192'(occupancy), 192'(0));
    chk("rst_out_rec", 192'({out_src, out_tag, out_entry}), 192'(0));
    chk("rst_ovf", 192'(overflow_count), 192'(0));
    cyc();
    if_valid = 1'b0; rst = 1'b0;

    // Single IF push reaches the head one cycle later
    if_valid = 1'b1; if_entry = 128'hA5;
    neg();
    chk("t1_if_ready", 192'(if_ready), 192'(1));
    push_exp(1'b0, 0, 128'hA5);
    cyc();
    if_valid = 1'b0;
    neg();
    chk("t1_out_valid", 192'(out_valid), 192'(1));
    chk("t1_occ", 192'(occupancy), 192'(1));
    chk("t1_out_tag", 192'(out_tag), 192'(0));
    chk("t1_out_src", 192'(out_src), 192'(0));
    cyc();
    drain(2);

    // Both valid: IF, MEM, IF, MEM with tags 0..3 while draining
    do_reset();
    if_valid = 1'b1; mem_valid = 1'b1; out_ready = 1'b1;
    if_entry = 128'h11; mem_entry = 128'h22;
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("rr_if_ready", 192'(if_ready), 192'(!g[k]));
      chk("rr_mem_ready", 192'(mem_ready), 192'(g[k]));
      push_exp(g[k], k, g[k] ? 128'h22 : 128'h11);
      cyc();
    end
    if_valid = 1'b0; mem_valid = 1'b0;
    drain(3);

`ifndef TRACE_ARB_OVERWRITE_EN
    // Backpressure when full, also while a pop is in progress
    do_reset();
    if_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_entry = EW'(8'h30 + k);
      neg();
      chk("bp_if_ready", 192'(if_ready), 192'(1));
      push_exp(1'b0, k, EW'(8'h30 + k));
      cyc();
    end
    if_entry = 128'h34;
    neg();
    chk("bp_full_ready", 192'(if_ready), 192'(0));
    chk("bp_full_occ", 192'(occupancy), 192'(4));
    cyc();
    out_ready = 1'b1;
    neg();
    chk("bp_full_pop_ready", 192'(if_ready), 192'(0));
    cyc();
    out_ready = 1'b0;
    neg();
    chk("bp_after_pop_ready", 192'(if_ready), 192'(1));
    chk("bp_after_pop_occ", 192'(occupancy), 192'(3));
    chk("bp_ovf_const", 192'(overflow_count), 192'(0));
    push_exp(1'b0, 4, 128'h34);
    cyc();
    if_valid = 1'b0;
    drain(5);
`else
    // Overwrite when full: two oldest records are lost
    do_reset();
    if_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if_entry = EW'(8'h40 + k);
      neg();
      chk("ow_if_ready", 192'(if_ready), 192'(1));
      push_exp(1'b0, k, EW'(8'h40 + k));
      cyc();
    end
    if_valid = 1'b0;
    neg();
    chk("ow_occ", 192'(occupancy), 192'(4));
    chk("ow_ovf", 192'(overflow_count), 192'(2));
    chk("ow_head_tag", 192'(out_tag), 192'(2));
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    cyc();
    drain(5);
`endif

    // Flush discards stored records and a coincident handshake, tags continue
    do_reset();
    if_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_entry = EW'(8'h50 + k);
      neg();
      chk("fl_if_ready", 192'(if_ready), 192'(1));
      push_exp(1'b0, k, EW'(8'h50 + k));
      cyc();
    end
    flush = 1'b1; if_entry = 128'h5F;
    neg();
    chk("fl_pulse_ready", 192'(if_ready), 192'(1));
    cyc();
    flush = 1'b0; if_entry = 128'h53;
    neg();
    chk("fl_state_ready", 192'(if_ready), 192'(0));
    chk("fl_occ", 192'(occupancy), 192'(0));
    chk("fl_out_valid", 192'(out_valid), 192'(0));
    exp_q.delete();
    cyc();
    neg();
    chk("fl_resume_ready", 192'(if_ready), 192'(1));
    push_exp(1'b0, 3, 128'h53);
    cyc();
    if_valid = 1'b0;
    neg();
    chk("fl_next_tag", 192'(out_tag), 192'(3));
    cyc();
    drain(2);

    // Halt blocks acceptance while drain continues
    do_reset();
    if_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_entry = EW'(8'h60 + k);
      neg();
      chk("ht_if_ready", 192'(if_ready), 192'(1));
      push_exp(1'b0, k, EW'(8'h60 + k));
      cyc();
    end
    if_valid = 1'b0; halt = 1'b1;
    cyc();
    mem_valid = 1'b1; mem_entry = 128'h70; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("ht_mem_ready", 192'(mem_ready), 192'(0));
      cyc();
    end
    out_ready = 1'b0;
    neg();
    chk("ht_drained_occ", 192'(occupancy), 192'(0));
    cyc();
    halt = 1'b0;
    neg();
    chk("ht_release_ready", 192'(mem_ready), 192'(0));
    cyc();
    neg();
    chk("ht_run_ready", 192'(mem_ready), 192'(1));
    push_exp(1'b1, 2, 128'h70);
    cyc();
    mem_valid = 1'b0;
    drain(2);

    neg();
    chk("sb_empty", 192'(exp_q.size()), 192'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
